// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// several writeback sources, with a registered output stage and a contention counter.

package system_widths_pkg;
  localparam int REG_W = 32;
endpackage

module regfile_wb_arbiter
  import system_widths_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = REG_W,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*5-1:0]      req_waddr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      flush,
  output logic                      rf_wen,
  output logic [4:0]                rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      busy_waddr_valid,
  output logic [CNT_W-1:0]          contention_cnt,
  input  logic                      cnt_clear
);

  localparam int LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [LG_W-1:0]    last_grant;
  logic [LG_W-1:0]    grant_idx;
  logic [LG_W-1:0]    scan_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant;
  logic [4:0]         sel_waddr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [3:0]         num_valid;
  logic               multi_valid;
  logic               xfer;

  // Scan from the requester after the last winner, wrapping; first valid wins.
  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    grant     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = LG_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    grant[grant_idx] = grant_any;
  end

  // One-hot grant makes an AND-OR mux sufficient for the selected payload.
  always_comb begin
    sel_waddr = '0;
    sel_wdata = '0;
    num_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_waddr = req_waddr[5*i +: 5];
        sel_wdata = req_wdata[DATA_W*i +: DATA_W];
      end
      num_valid = num_valid + {3'b000, req_valid[i]};
    end
  end

  assign multi_valid      = (num_valid >= 4'd2);
  assign req_ready        = grant & {NUM_REQ{~flush}};
  assign xfer             = grant_any & ~flush;
  assign busy_waddr_valid = rf_wen;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rf_wen         <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      contention_cnt <= '0;
      last_grant     <= LG_W'(NUM_REQ - 1);
    end else begin
      // A write to x0 still completes the handshake but never reaches the regfile.
      rf_wen <= xfer && (sel_waddr != 5'd0);
      if (xfer) begin
        last_grant <= grant_idx;
        rf_waddr   <= sel_waddr;
        rf_wdata   <= sel_wdata;
      end
      if (cnt_clear)
        contention_cnt <= '0;
      else if (multi_valid && (contention_cnt != {CNT_W{1'b1}}))
        contention_cnt <= contention_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: three requesters, 32-bit data and a
// 4-bit contention counter so that saturation is reachable in a few cycles.

module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;

  logic                      clk;
  logic                      resetN;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*5-1:0]      req_waddr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      flush;
  logic                      rf_wen;
  logic [4:0]                rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic                      busy_waddr_valid;
  logic [CNT_W-1:0]          contention_cnt;
  logic                      cnt_clear;

  int n_cmp = 0;
  int n_mis = 0;

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .resetN           (resetN),
    .req_valid        (req_valid),
    .req_waddr        (req_waddr),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .flush            (flush),
    .rf_wen           (rf_wen),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .busy_waddr_valid (busy_waddr_valid),
    .contention_cnt   (contention_cnt),
    .cnt_clear        (cnt_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [DATA_W-1:0] d);
    req_waddr[5*i +: 5]           = a;
    req_wdata[DATA_W*i +: DATA_W] = d;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    req_valid = '0;
    flush     = 1'b0;
    cnt_clear = 1'b0;
    resetN    = 1'b0;
    #2;
    resetN    = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (rf_wen !== 1'b0) begin n_mis++; $display("FAIL reset_wen: got %0b want 0", rf_wen); end
    n_cmp++; if (rf_waddr !== 5'd0) begin n_mis++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'h0) begin n_mis++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
    n_cmp++; if (contention_cnt !== 4'd0) begin n_mis++; $display("FAIL reset_cnt: got %0d want 0", contention_cnt); end
    n_cmp++; if (req_ready !== 3'b000) begin n_mis++; $display("FAIL reset_ready: got %b want 000", req_ready); end
  endtask

  task automatic test_single();
    set_req(0, 5'd5, 32'h0000_00A5);
    req_valid = 3'b001;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_mis++; $display("FAIL single_ready: got %b want 001", req_ready); end
    step();
    req_valid = 3'b000;
    n_cmp++; if (rf_wen !== 1'b1) begin n_mis++; $display("FAIL single_wen: got %0b want 1", rf_wen); end
    n_cmp++; if (busy_waddr_valid !== 1'b1) begin n_mis++; $display("FAIL single_busy: got %0b want 1", busy_waddr_valid); end
    n_cmp++; if (rf_waddr !== 5'd5) begin n_mis++; $display("FAIL single_waddr: got %0d want 5", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'hA5) begin n_mis++; $display("FAIL single_wdata: got %h want a5", rf_wdata); end
    step();
    n_cmp++; if (rf_wen !== 1'b0) begin n_mis++; $display("FAIL single_wen_drop: got %0b want 0", rf_wen); end
    n_cmp++; if (rf_waddr !== 5'd5) begin n_mis++; $display("FAIL single_waddr_hold: got %0d want 5", rf_waddr); end
  endtask

  // All three valid; each requester drops valid after its second grant.
  task automatic test_round_robin();
    int grants [NUM_REQ];
    int g;
    logic [NUM_REQ-1:0] exp_ready;
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, 5'(i + 1), 32'h100 + i);
      grants[i] = 0;
    end
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NUM_REQ; i++) req_valid[i] = (grants[i] < 2);
      g = c % 3;
      exp_ready = '0;
      exp_ready[g] = 1'b1;
      #1;
      n_cmp++; if (req_ready !== exp_ready) begin n_mis++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, exp_ready); end
      step();
      grants[g]++;
      n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'(g + 1) || rf_wdata !== 32'h100 + g)
        begin n_mis++; $display("FAIL rr_write[%0d]: got wen=%0b addr=%0d data=%h want wen=1 addr=%0d", c, rf_wen, rf_waddr, rf_wdata, g + 1); end
    end
    req_valid = '0;
    n_cmp++; if (contention_cnt !== 4'd5) begin n_mis++; $display("FAIL rr_cnt: got %0d want 5", contention_cnt); end
    step();
    n_cmp++; if (rf_wen !== 1'b0) begin n_mis++; $display("FAIL rr_idle_wen: got %0b want 0", rf_wen); end
  endtask

  // Pointer sits at 2, so requester 1 (x0 write) goes before requester 2.
  task automatic test_x0_drop();
    set_req(1, 5'd0, 32'hDEAD_0001);
    set_req(2, 5'd7, 32'h0000_0777);
    req_valid = 3'b110;
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_mis++; $display("FAIL x0_ready1: got %b want 010", req_ready); end
    step();
    req_valid = 3'b100;
    n_cmp++; if (rf_wen !== 1'b0) begin n_mis++; $display("FAIL x0_wen: got %0b want 0", rf_wen); end
    n_cmp++; if (req_ready !== 3'b100) begin n_mis++; $display("FAIL x0_ready2: got %b want 100", req_ready); end
    step();
    req_valid = 3'b000;
    n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h777)
      begin n_mis++; $display("FAIL x0_next_write: got wen=%0b addr=%0d data=%h want 1/7/777", rf_wen, rf_waddr, rf_wdata); end
    n_cmp++; if (contention_cnt !== 4'd6) begin n_mis++; $display("FAIL x0_cnt: got %0d want 6", contention_cnt); end
    step();
  endtask

  // Pointer at 2 going in; a pointer move during flush would make 1 win next.
  task automatic test_flush();
    set_req(0, 5'd9, 32'h0000_0099);
    set_req(1, 5'd10, 32'h0000_00AA);
    req_valid = 3'b011;
    flush     = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (req_ready !== 3'b000) begin n_mis++; $display("FAIL flush_ready[%0d]: got %b want 000", c, req_ready); end
      step();
      n_cmp++; if (rf_wen !== 1'b0) begin n_mis++; $display("FAIL flush_wen[%0d]: got %0b want 0", c, rf_wen); end
    end
    flush = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_mis++; $display("FAIL flush_release_ready: got %b want 001", req_ready); end
    step();
    req_valid = 3'b000;
    n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd9)
      begin n_mis++; $display("FAIL flush_release_write: got wen=%0b addr=%0d want 1/9", rf_wen, rf_waddr); end
    n_cmp++; if (contention_cnt !== 4'd9) begin n_mis++; $display("FAIL flush_cnt: got %0d want 9", contention_cnt); end
    step();
  endtask

  task automatic test_saturation();
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    n_cmp++; if (contention_cnt !== 4'd0) begin n_mis++; $display("FAIL sat_clear_idle: got %0d want 0", contention_cnt); end
    req_valid = 3'b011;
    repeat (20) step();
    n_cmp++; if (contention_cnt !== 4'd15) begin n_mis++; $display("FAIL sat_value: got %0d want 15", contention_cnt); end
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    n_cmp++; if (contention_cnt !== 4'd0) begin n_mis++; $display("FAIL sat_clear_prio: got %0d want 0", contention_cnt); end
    step();
    n_cmp++; if (contention_cnt !== 4'd1) begin n_mis++; $display("FAIL sat_restart: got %0d want 1", contention_cnt); end
    req_valid = 3'b000;
    step();
  endtask

  task automatic test_async_reset();
    set_req(0, 5'd3, 32'h0000_0033);
    req_valid = 3'b001;
    step();
    n_cmp++; if (rf_wen !== 1'b1) begin n_mis++; $display("FAIL areset_pre_wen: got %0b want 1", rf_wen); end
    req_valid = 3'b011;
    #2;
    resetN = 1'b0;
    #1;
    n_cmp++; if (rf_wen !== 1'b0) begin n_mis++; $display("FAIL areset_wen: got %0b want 0", rf_wen); end
    n_cmp++; if (rf_waddr !== 5'd0 || contention_cnt !== 4'd0)
      begin n_mis++; $display("FAIL areset_state: got addr=%0d cnt=%0d want 0/0", rf_waddr, contention_cnt); end
    #1;
    resetN = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_mis++; $display("FAIL areset_first_grant: got %b want 001", req_ready); end
    step();
    req_valid = 3'b000;
    n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd3)
      begin n_mis++; $display("FAIL areset_first_write: got wen=%0b addr=%0d want 1/3", rf_wen, rf_waddr); end
  endtask

  initial begin
    resetN    = 1'b0;
    req_valid = '0;
    req_waddr = '0;
    req_wdata = '0;
    flush     = 1'b0;
    cnt_clear = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_x0_drop();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
